// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the inter-stage pipeline registers.
//   - pipe_state_e : occupancy encoding of the skid register
//                    (ST_EMPTY / ST_ONE / ST_FULL; the fourth code is illegal)
//   - IFID_*       : field layout of the packed IF/ID payload bus
//   - ifid_pack    : helper that builds an IF/ID payload from its fields
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int IFID_W         = 64;
    localparam int IFID_PC_LSB    = 32;
    localparam int IFID_INSTR_LSB = 0;

    function automatic logic [IFID_W-1:0] ifid_pack(input logic [31:0] pc_plus4,
                                                    input logic [31:0] instr);
        logic [IFID_W-1:0] bus;
        bus = '0;
        bus[IFID_PC_LSB +: 32]    = pc_plus4;
        bus[IFID_INSTR_LSB +: 32] = instr;
        return bus;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// ---------------------------------------------------------------------------
// pipe_sat_cnt
//   CNT_W-bit event counter that increments while 'en' is high and sticks at
//   all-ones instead of wrapping.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-low reset (counter cleared to 0)
//     en    - count this cycle
//     cnt   - current count
// ---------------------------------------------------------------------------
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Generic inter-stage pipeline register with a valid/ready handshake and a
//   two-entry skid buffer (main_q presented downstream, skid_q catches the
//   beat that arrives while downstream stalls). in_ready is decoded purely
//   from the state flop, so no combinational ready path crosses stages.
//   A synchronous flush empties the register and reloads both payload
//   registers with FLUSH_VAL.
//
//   Optional feature macro: PIPE_SKID_PERF_EN adds saturating stall/flush
//   performance counters (ports stall_cnt, flush_cnt).
//
//   Ports:
//     clk       - rising-edge clock
//     reset     - asynchronous, active-low reset
//     flush     - synchronous flush, active-high
//     in_valid  - upstream beat valid
//     in_ready  - register can accept a beat (state decode only)
//     in_data   - upstream payload
//     out_valid - payload valid to downstream
//     out_ready - downstream accepts
//     out_data  - payload to downstream (always main_q)
//     stall_cnt - [PIPE_SKID_PERF_EN] cycles with out_valid & ~out_ready
//     flush_cnt - [PIPE_SKID_PERF_EN] flush cycles that discarded a beat
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = IFID_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    logic in_fire;
    logic out_fire;

    // A beat offered during a flush is dropped, so it never counts as accepted.
    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) state_d = ST_ONE;
            end
            ST_ONE: begin
                if (in_fire && !out_fire)      state_d = ST_FULL;
                else if (!in_fire && out_fire) state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (out_fire) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Output decode
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q != ST_FULL);
        out_data  = main_q;
    end

    // Payload steering. When draining to EMPTY main_q keeps its last value;
    // the skid entry is scrubbed back to FLUSH_VAL once promoted.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) main_d = in_data;
            end
            ST_ONE: begin
                if (in_fire && out_fire)  main_d = in_data;
                if (in_fire && !out_fire) skid_d = in_data;
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d = skid_q;
                    skid_d = FLUSH_VAL;
                end
            end
            default: begin
                main_d = FLUSH_VAL;
                skid_d = FLUSH_VAL;
            end
        endcase
        if (flush) begin
            main_d = FLUSH_VAL;
            skid_d = FLUSH_VAL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= FLUSH_VAL;
            skid_q <= FLUSH_VAL;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic stall_en;
    logic flush_en;

    assign stall_en = out_valid & ~out_ready;
    assign flush_en = flush & (state_q != ST_EMPTY);

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en),
        .cnt   (stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_en),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Scoreboard bench for pipe_skid_reg. The stimulus side pushes each beat the
//   reference model says is accepted into exp_q; an independent negedge
//   monitor pops and compares whenever the DUT hands a beat downstream.
//   The reference model is a plain occupancy count (0..2) plus the FIFO
//   of expected beats.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int          DATA_W  = 64;
    localparam int          CNT_W   = 4;
    localparam logic [63:0] FLUSH_V = 64'h0;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    pipe_skid_reg #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_V),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [63:0] exp_q[$];
    int          model_cnt  = 0;
    logic [63:0] model_idle = FLUSH_V;
    int          model_stall = 0;
    int          model_flush = 0;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. Called at posedge+1, returns at the next
    // posedge+1 with the model advanced over that edge.
    task automatic applyStimulus(input logic v, input logic [63:0] d,
                                 input logic r, input logic f, output logic acc);
        logic        dep;
        logic [63:0] dep_data;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        acc       = v && (model_cnt < 2) && !f;
        dep       = (model_cnt > 0) && r;
        dep_data  = (dep && exp_q.size() > 0) ? exp_q[0] : FLUSH_V;
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (model_cnt > 0 && !r && model_stall < CNT_MAX) model_stall++;
        if (f && model_cnt > 0 && model_flush < CNT_MAX) model_flush++;
        if (f) begin
            model_cnt  = 0;
            model_idle = FLUSH_V;
            exp_q.delete();
        end else begin
            model_cnt = model_cnt + int'(acc) - int'(dep);
            if (dep && model_cnt == 0) model_idle = dep_data;
        end
    endtask

    // Offer a beat until the model says it was taken (bounded retries).
    task automatic sendBeat(input logic [63:0] d, input logic r);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            applyStimulus(1'b1, d, r, 1'b0, acc);
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("[TB] FAIL send_%0h: got not_accepted expected accepted", d);
        end
    endtask

    task automatic idleCycles(input int n, input logic r);
        logic acc;
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 64'h0, r, 1'b0, acc);
    endtask

    task automatic modelReset();
        model_cnt   = 0;
        model_idle  = FLUSH_V;
        model_stall = 0;
        model_flush = 0;
        exp_q.delete();
    endtask

    // Monitor: compares DUT outputs against the model between edges and pops
    // the scoreboard for every beat handed downstream.
    always @(negedge clk) begin
        logic [63:0] exp;
        checkOutput("out_valid", 64'(out_valid), 64'(model_cnt > 0));
        checkOutput("in_ready", 64'(in_ready), 64'(model_cnt < 2));
        if (model_cnt == 0) checkOutput("idle_data", out_data, model_idle);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got beat %0h expected none", out_data);
            end else begin
                exp = exp_q.pop_front();
                checkOutput("out_data", out_data, exp);
            end
        end
`ifdef PIPE_SKID_PERF_EN
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(model_stall));
        checkOutput("flush_cnt", 64'(flush_cnt), 64'(model_flush));
`endif
    end

    initial begin
        logic acc;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD;
        out_ready = 1'b1;
        reset     = 1'b1;
        #1 reset  = 1'b0;

        // Held in reset with a beat offered: nothing is taken.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'h1);
        checkOutput("rst_out_data", out_data, FLUSH_V);
        reset = 1'b1;
        applyStimulus(1'b1, 64'hDEAD, 1'b1, 1'b0, acc);
        idleCycles(2, 1'b1);

        // Back-to-back streaming
        for (int i = 1; i <= 8; i++) sendBeat(64'(i), 1'b1);
        idleCycles(2, 1'b1);

        // Skid fill, then drain in order
        sendBeat(64'hA1, 1'b0);
        sendBeat(64'hA2, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 64'hA3, 1'b0, 1'b0, acc);
        sendBeat(64'hA3, 1'b1);
        idleCycles(3, 1'b1);

        // Flush while FULL with a beat offered
        sendBeat(64'hB1, 1'b0);
        sendBeat(64'hB2, 1'b0);
        applyStimulus(1'b1, 64'hB3, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 64'hB3, 1'b0, 1'b1, acc);
        idleCycles(2, 1'b1);

        // Stall-counter saturation
        sendBeat(64'hC1, 1'b0);
        idleCycles(20, 1'b0);
        idleCycles(2, 1'b1);

        // Asynchronous reset between edges while FULL
        sendBeat(64'hD1, 1'b0);
        sendBeat(64'hD2, 1'b0);
        #2;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        checkOutput("async_out_valid", 64'(out_valid), 64'h0);
        checkOutput("async_in_ready", 64'(in_ready), 64'h1);
        checkOutput("async_out_data", out_data, FLUSH_V);
        modelReset();
        @(posedge clk);
        #1 reset = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, {$urandom, $urandom},
                          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, acc);
        end
        idleCycles(4, 1'b1);
        checkOutput("drained", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
